// File: rtl/tl_ul_ram_responder.sv
// rtl/tl_ul_ram_responder.sv - TL-UL slave answering Get/PutFull/PutPartial from a flop-array memory
module tl_ul_ram_responder #(
    parameter int                 SIZE_WD   = 3,
    parameter int                 ADDR_WD   = 36,
    parameter int                 DATA_WD   = 256,
    parameter int                 SOURCE_WD = 32,
    parameter int                 SINK_WD   = 32,
    parameter int                 DEPTH     = 64,
    parameter logic [ADDR_WD-1:0] BASE_ADDR = '0,
    parameter int                 MAX_SIZE  = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2:0]             a_opcode,
    input  logic [2:0]             a_param,
    input  logic [SIZE_WD-1:0]     a_size,
    input  logic [SOURCE_WD-1:0]   a_source,
    input  logic [ADDR_WD-1:0]     a_address,
    input  logic [DATA_WD/8-1:0]   a_mask,
    input  logic [DATA_WD-1:0]     a_data,
    input  logic                   a_corrupt,
    input  logic                   a_valid,
    output logic                   a_ready,
    output logic [2:0]             d_opcode,
    output logic [1:0]             d_param,
    output logic [SIZE_WD-1:0]     d_size,
    output logic [SOURCE_WD-1:0]   d_source,
    output logic [SINK_WD-1:0]     d_sink,
    output logic                   d_denied,
    output logic [DATA_WD-1:0]     d_data,
    output logic                   d_corrupt,
    output logic                   d_valid,
    input  logic                   d_ready
);
    localparam int BYTES = DATA_WD / 8;
    localparam int BB    = $clog2(BYTES);
    localparam int CW    = $clog2((2 ** MAX_SIZE) / BYTES) + 1;
    localparam int IW    = $clog2(DEPTH);
    localparam int XW    = ADDR_WD + 1;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PUT_DATA = 2'd1,
        GET_RESP = 2'd2,
        ACK      = 2'd3
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]        beat, beat_n;
    logic [SIZE_WD-1:0]   req_size;
    logic [SOURCE_WD-1:0] req_source;
    logic [IW-1:0]        req_idx;
    logic [CW-1:0]        req_last;
    logic                 req_bad;
    logic                 req_full;

    logic [DATA_WD-1:0]   mem [DEPTH];

    logic                 a_fire, d_fire;
    logic [XW-1:0]        a_off_x, a_base, a_nb, a_end, a_last_x;
    logic                 a_below, a_bad_geom;
    logic [CW-1:0]        a_last;
    logic [IW-1:0]        a_idx;

    logic                 req_load, bad_n, we, we_full;
    logic [IW-1:0]        we_idx, rd_idx, nxt_idx;
    logic [BYTES-1:0]     we_be;
    logic [SIZE_WD-1:0]   nxt_size;
    logic [SOURCE_WD-1:0] nxt_source;
    logic                 d_live_n;

    logic                 unused_ok;
    assign unused_ok = ^{a_param, a_last_x[XW-1:CW], a_base[XW-1:IW]};

    assign a_ready  = !reset && ((state == IDLE) || (state == PUT_DATA));
    assign a_fire   = a_valid && a_ready;
    assign d_fire   = d_valid && d_ready;
    assign d_param  = '0;
    assign d_sink   = '0;

    // Request geometry: beat count, starting index and the out-of-range check
    always_comb begin
        a_off_x    = {1'b0, a_address} - {1'b0, BASE_ADDR};
        a_below    = a_off_x[XW-1];
        a_base     = {1'b0, a_off_x[ADDR_WD-1:0] >> BB};
        a_nb       = (a_size <= SIZE_WD'(BB)) ? XW'(1) : (XW'(1) << (a_size - SIZE_WD'(BB)));
        a_end      = a_base + a_nb - XW'(1);
        a_last_x   = a_nb - XW'(1);
        a_last     = a_last_x[CW-1:0];
        a_idx      = a_base[IW-1:0];
        a_bad_geom = (a_size > SIZE_WD'(MAX_SIZE)) || a_below || (a_end >= XW'(DEPTH));
    end

    // Next-state, write-enable and request-capture decisions
    always_comb begin
        state_n  = state;
        beat_n   = beat;
        req_load = 1'b0;
        bad_n    = req_bad;
        we       = 1'b0;
        we_idx   = req_idx + IW'(beat);
        we_full  = req_full;
        case (state)
            IDLE: begin
                if (a_fire) begin
                    req_load = 1'b1;
                    beat_n   = '0;
                    bad_n    = a_bad_geom;
                    we_idx   = a_idx;
                    we_full  = (a_opcode == OP_PUT_FULL);
                    case (a_opcode)
                        OP_GET: state_n = GET_RESP;
                        OP_PUT_FULL, OP_PUT_PART, 3'd2, 3'd3: begin
                            if (a_opcode == OP_PUT_FULL || a_opcode == OP_PUT_PART) begin
                                we = !a_bad_geom && !a_corrupt;
                            end else begin
                                bad_n = 1'b1;
                            end
                            if (a_last == '0) begin
                                state_n = ACK;
                            end else begin
                                state_n = PUT_DATA;
                                beat_n  = CW'(1);
                            end
                        end
                        default: begin
                            bad_n   = 1'b1;
                            state_n = ACK;
                        end
                    endcase
                end
            end
            PUT_DATA: begin
                if (a_fire) begin
                    we = !req_bad && !a_corrupt;
                    if (beat == req_last) begin
                        state_n = ACK;
                    end else begin
                        beat_n = beat + CW'(1);
                    end
                end
            end
            GET_RESP: begin
                if (d_fire) begin
                    if (beat == req_last) begin
                        state_n = IDLE;
                    end else begin
                        beat_n = beat + CW'(1);
                    end
                end
            end
            ACK: begin
                if (d_fire) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        we_be      = we_full ? '1 : a_mask;
        nxt_size   = req_load ? a_size : req_size;
        nxt_source = req_load ? a_source : req_source;
        nxt_idx    = req_load ? a_idx : req_idx;
        rd_idx     = nxt_idx + IW'(beat_n);
        d_live_n   = (state_n == GET_RESP) || (state_n == ACK);
    end

    // State register and beat counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
        end
    end

    // Request fields captured at the first A beat
    always_ff @(posedge clock) begin
        if (reset) begin
            req_size   <= '0;
            req_source <= '0;
            req_idx    <= '0;
            req_last   <= '0;
            req_bad    <= 1'b0;
            req_full   <= 1'b0;
        end else if (req_load) begin
            req_size   <= a_size;
            req_source <= a_source;
            req_idx    <= a_idx;
            req_last   <= a_last;
            req_bad    <= bad_n;
            req_full   <= (a_opcode == OP_PUT_FULL);
        end
    end

    // Byte-masked memory write at the A fire edge; contents survive reset
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (we_be[i]) begin
                    mem[we_idx][i*8 +: 8] <= a_data[i*8 +: 8];
                end
            end
        end
    end

    // Registered D channel; recomputes identical values while stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            d_valid   <= 1'b0;
            d_opcode  <= '0;
            d_size    <= '0;
            d_source  <= '0;
            d_denied  <= 1'b0;
            d_corrupt <= 1'b0;
            d_data    <= '0;
        end else begin
            d_valid   <= d_live_n;
            d_opcode  <= (state_n == GET_RESP) ? 3'd1 : 3'd0;
            d_size    <= d_live_n ? nxt_size : '0;
            d_source  <= d_live_n ? nxt_source : '0;
            d_denied  <= d_live_n && bad_n;
            d_corrupt <= (state_n == GET_RESP) && bad_n;
            d_data    <= ((state_n == GET_RESP) && !bad_n) ? mem[rd_idx] : '0;
        end
    end
endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// tb/tb_tl_ul_ram_responder.sv - randomized self-checking bench for tl_ul_ram_responder
module tb_tl_ul_ram_responder;
    logic         clock = 1'b0;
    logic         reset;
    logic [2:0]   a_opcode, a_param;
    logic [2:0]   a_size;
    logic [31:0]  a_source;
    logic [35:0]  a_address;
    logic [31:0]  a_mask;
    logic [255:0] a_data;
    logic         a_corrupt, a_valid, a_ready;
    logic [2:0]   d_opcode;
    logic [1:0]   d_param;
    logic [2:0]   d_size;
    logic [31:0]  d_source, d_sink;
    logic         d_denied, d_corrupt, d_valid, d_ready;
    logic [255:0] d_data;

    tl_ul_ram_responder dut (
        .clock(clock), .reset(reset),
        .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
        .a_valid(a_valid), .a_ready(a_ready),
        .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
        .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt),
        .d_valid(d_valid), .d_ready(d_ready)
    );

    always #5 clock = ~clock;

    int tests_run = 0;
    int fails     = 0;

    logic [255:0] mem_m [64];
    logic [255:0] wdata [4];
    logic [31:0]  wmask [4];
    logic         wcorr [4];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic fill_beats(input logic [255:0] d, input logic [31:0] m);
        for (int i = 0; i < 4; i++) begin
            wdata[i] = d;
            wmask[i] = m;
            wcorr[i] = 1'b0;
        end
    endtask

    // One complete request/response exchange, judged against the reference memory
    task automatic run_txn(input logic [2:0] op, input logic [2:0] size, input logic [35:0] addr,
                           input logic [31:0] src, input int max_stall);
        int sz, nb, base, na, nd, cnt, stall;
        logic bad;
        logic [255:0] exp_data;
        sz   = int'(size);
        nb   = (sz <= 5) ? 1 : (1 << (sz - 5));
        base = int'(addr >> 5);
        bad  = (sz > 6) || (base + nb - 1 >= 64);
        if (op == 3'd4) begin
            na = 1; nd = nb;
        end else if (op <= 3'd3) begin
            na = nb; nd = 1;
            if (op >= 3'd2) bad = 1'b1;
        end else begin
            na = 1; nd = 1; bad = 1'b1;
        end

        for (int b = 0; b < na; b++) begin
            a_valid   = 1'b1;
            a_opcode  = op;
            a_size    = size;
            a_address = addr;
            a_source  = src;
            a_mask    = wmask[b];
            a_data    = wdata[b];
            a_corrupt = wcorr[b];
            cnt = 0;
            while (a_ready !== 1'b1 && cnt < 20) begin
                @(posedge clock); #1;
                cnt++;
            end
            check("a_ready_wait", 256'(a_ready), 256'(1));
            @(posedge clock); #1;
            if (op <= 3'd1 && !bad && !wcorr[b]) begin
                for (int j = 0; j < 32; j++) begin
                    if (op == 3'd0 || wmask[b][j]) mem_m[base + b][j*8 +: 8] = wdata[b][j*8 +: 8];
                end
            end
        end
        a_valid   = 1'b0;
        a_corrupt = 1'b0;

        for (int b = 0; b < nd; b++) begin
            exp_data = '0;
            if (op == 3'd4 && !bad) exp_data = mem_m[base + b];
            check("d_valid", 256'(d_valid), 256'(1));
            check("d_opcode", 256'(d_opcode), (op == 3'd4) ? 256'(1) : 256'(0));
            check("d_denied", 256'(d_denied), 256'(bad));
            check("d_corrupt", 256'(d_corrupt), 256'(op == 3'd4 && bad));
            check("d_size", 256'(d_size), 256'(size));
            check("d_source", 256'(d_source), 256'(src));
            check("d_param_sink", 256'({d_param, d_sink}), 256'(0));
            check("d_data", d_data, exp_data);
            check("a_ready_busy", 256'(a_ready), 256'(0));
            stall   = $urandom_range(0, max_stall);
            d_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(posedge clock); #1;
                check("d_hold_valid", 256'(d_valid), 256'(1));
                check("d_hold_data", d_data, exp_data);
            end
            d_ready = 1'b1;
            @(posedge clock); #1;
            d_ready = 1'b0;
        end
        check("d_idle", 256'(d_valid), 256'(0));
        check("a_ready_idle", 256'(a_ready), 256'(1));
    endtask

    initial begin
        logic [2:0] op, size;
        int r;
        reset = 1'b1; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0; a_address = '0;
        a_mask = '0; a_data = '0; a_corrupt = 1'b0; a_valid = 1'b0; d_ready = 1'b0;

        @(posedge clock); #1;
        check("rst_a_ready", 256'(a_ready), 256'(0));
        check("rst_d_valid", 256'(d_valid), 256'(0));
        reset = 1'b0; #1;
        check("post_rst_a_ready", 256'(a_ready), 256'(1));
        check("post_rst_d_all", 256'({d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_valid}), 256'(0));
        check("post_rst_d_data", d_data, 256'(0));

        // Give every beat a known random value
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < 4; k++) begin
                wdata[k] = rand256(); wmask[k] = '1; wcorr[k] = 1'b0;
            end
            run_txn(3'd0, 3'd6, 36'(i * 64), $urandom, 0);
        end

        fill_beats({32{8'hA5}}, '1);
        run_txn(3'd0, 3'd5, 36'h40, 32'h11, 1);
        run_txn(3'd4, 3'd5, 36'h40, 32'h12, 1);

        fill_beats('0, '1);
        run_txn(3'd0, 3'd5, 36'h0, 32'h1, 0);
        fill_beats({256{1'b1}}, 32'h0000000F);
        run_txn(3'd1, 3'd5, 36'h0, 32'h2, 2);
        run_txn(3'd4, 3'd5, 36'h0, 32'h3, 0);

        run_txn(3'd4, 3'd6, 36'h80, 32'h4, 3);
        run_txn(3'd4, 3'd5, 36'h800, 32'h5, 1);

        fill_beats(rand256(), '1);
        run_txn(3'd0, 3'd6, 36'h7E0, 32'h6, 1);
        run_txn(3'd4, 3'd5, 36'h7E0, 32'h7, 0);

        run_txn(3'd6, 3'd0, 36'h0, 32'h7, 1);

        fill_beats(rand256(), '1);
        run_txn(3'd2, 3'd6, 36'h0, 32'h8, 1);
        run_txn(3'd4, 3'd6, 36'h0, 32'h9, 0);

        fill_beats(rand256(), '1);
        wdata[1] = rand256();
        wcorr[1] = 1'b1;
        run_txn(3'd0, 3'd6, 36'h100, 32'hA, 0);
        run_txn(3'd4, 3'd6, 36'h100, 32'hB, 1);

        fill_beats(rand256(), '1);
        run_txn(3'd0, 3'd7, 36'h0, 32'hC, 0);
        run_txn(3'd4, 3'd7, 36'h0, 32'hD, 0);

        fill_beats(rand256(), 32'hF0F0_00FF);
        run_txn(3'd1, 3'd2, 36'h47, 32'hE, 0);
        run_txn(3'd4, 3'd0, 36'h5F, 32'hF, 1);

        // Reset in the middle of a two-beat Get
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 3'd6; a_address = 36'h80; a_source = 32'h55;
        @(posedge clock); #1;
        a_valid = 1'b0;
        check("mid_beat0_valid", 256'(d_valid), 256'(1));
        check("mid_beat0_data", d_data, mem_m[4]);
        d_ready = 1'b1;
        @(posedge clock); #1;
        d_ready = 1'b0;
        check("mid_beat1_data", d_data, mem_m[5]);
        reset = 1'b1; #1;
        check("mid_rst_a_ready", 256'(a_ready), 256'(0));
        @(posedge clock); #1;
        reset = 1'b0; #1;
        check("mid_rst_d_valid", 256'(d_valid), 256'(0));
        check("mid_rst_a_ready_after", 256'(a_ready), 256'(1));
        run_txn(3'd4, 3'd6, 36'h80, 32'h56, 1);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      op = 3'd0;
            else if (r < 5) op = 3'd1;
            else if (r < 8) op = 3'd4;
            else            op = 3'($urandom_range(2, 7));
            size = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            for (int k = 0; k < 4; k++) begin
                wdata[k] = rand256();
                wmask[k] = $urandom;
                wcorr[k] = ($urandom_range(0, 7) == 0);
            end
            run_txn(op, size, 36'($urandom_range(0, 32'h83F)), $urandom, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
